// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared full-adder cell processes the operands
// LSB-first, one bit per clock, with valid/ready handshakes on both sides.

module fa (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;

    fa u_fa (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // Reset is folded into the decode so the handshake outputs read low while it is held.
    assign in_ready  = !reset && (state == IDLE);
    assign out_valid = !reset && (state == DONE);
    assign busy      = !reset && (state != IDLE);

    // NOTE: every register here is assigned with <= so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= fa_co;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum   <= {fa_s, sum_sh[WIDTH-1:1]};
                        cout  <= fa_co;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
